tx_turbo_int_buf: RTL

//   TX-side turbo interleaver frame buffer; mirrors the RX deinterleaver address path.

---
 rtl/tx_turbo_int_buf.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/tx_turbo_int_buf.sv
// tx_turbo_int_buf: TX turbo interleaver ping-pong frame buffer.
// Symbols are written in natural order and each full bank is read out in permuted
// order, p(k+1) = (p(k) + S) mod N, with addresses generated on the fly (no ROM).
// Optional feature macro: TXI_FRAME_CNT_EN adds a 16-bit completed-frame counter port.
module tx_turbo_int_buf #(
    parameter int unsigned D_WIDTH = 2,
    parameter int unsigned A_WIDTH = 12
) (
    input  logic               clk,
    input  logic               n_rst,        // synchronous, active-high
    input  logic               mod_int_dint,
    input  logic [A_WIDTH-1:0] frame_len,
    input  logic [A_WIDTH-1:0] step,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [D_WIDTH-1:0] s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [D_WIDTH-1:0] m_data,
    output logic               m_last,
    output logic               cfg_err
`ifdef TXI_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_cnt
`endif
);

    localparam int unsigned DEPTH = 1 << A_WIDTH;
    localparam int unsigned SUM_W = A_WIDTH + 1;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_t;

    // storage and per-bank frame configuration
    logic [D_WIDTH-1:0] mem_q [2*DEPTH];
    logic [1:0]         full_q;
    logic [A_WIDTH-1:0] cfg_n_q [2];
    logic [A_WIDTH-1:0] cfg_s_q [2];
    logic [1:0]         cfg_mode_q;

    // write side
    logic               wbank_q;
    logic [A_WIDTH-1:0] wcnt_q;
    logic               cfg_err_q;

    // read side
    rd_state_t          rd_state_q;
    logic               rbank_q;
    logic [A_WIDTH-1:0] rcnt_q;
    logic [A_WIDTH-1:0] raddr_q;
    logic               m_valid_q;
    logic               m_last_q;
    logic [D_WIDTH-1:0] m_data_q;

    // combinational control
    logic [A_WIDTH-1:0] n_clamp;
    logic               first_beat;
    logic               bad_cfg;
    logic [A_WIDTH-1:0] wr_n;
    logic               wr_fire;
    logic               wr_last;
    logic [A_WIDTH-1:0] rd_n;
    logic [A_WIDTH-1:0] rd_s;
    logic               rd_mode;
    logic               rd_issue;
    logic               rd_last;
    logic [SUM_W-1:0]   addr_sum;
    logic [A_WIDTH-1:0] raddr_d;
    logic [1:0]         full_set;
    logic [1:0]         full_clr;

    assign s_ready = ~full_q[wbank_q];
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign cfg_err = cfg_err_q;

    // Frame length, step legality and write-beat qualification.
    always_comb begin
        n_clamp    = (frame_len == '0) ? A_WIDTH'(1) : frame_len;
        first_beat = (wcnt_q == '0);
        bad_cfg    = mod_int_dint & (step >= n_clamp);
        wr_n       = first_beat ? n_clamp : cfg_n_q[wbank_q];
        wr_fire    = s_valid & ~full_q[wbank_q];
        wr_last    = wr_fire & (wcnt_q == (wr_n - A_WIDTH'(1)));
    end

    // Read issue qualification and next permuted address (sum kept one bit wider).
    always_comb begin
        rd_n     = cfg_n_q[rbank_q];
        rd_s     = cfg_s_q[rbank_q];
        rd_mode  = cfg_mode_q[rbank_q];
        rd_issue = (rd_state_q == RD_RUN) & (~m_valid_q | m_ready) & (rcnt_q < rd_n);
        rd_last  = rd_issue & (rcnt_q == (rd_n - A_WIDTH'(1)));
        addr_sum = {1'b0, raddr_q} + {1'b0, rd_s};
        raddr_d  = raddr_q + A_WIDTH'(1);
        if (rd_mode) begin
            if (addr_sum >= {1'b0, rd_n}) begin
                raddr_d = A_WIDTH'(addr_sum - {1'b0, rd_n});
            end else begin
                raddr_d = A_WIDTH'(addr_sum);
            end
        end
    end

    // Bank full flag set/clear requests; write and read never target the same bank.
    always_comb begin
        full_set = 2'b00;
        full_clr = 2'b00;
        if (wr_last) begin
            full_set = wbank_q ? 2'b10 : 2'b01;
        end
        if (rd_last) begin
            full_clr = rbank_q ? 2'b10 : 2'b01;
        end
    end

    // Bank full flags.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            full_q <= 2'b00;
        end else begin
            full_q <= (full_q | full_set) & ~full_clr;
        end
    end

    // Symbol storage, natural-order write.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[{wbank_q, wcnt_q}] <= s_data;
        end
    end

    // Write pointer, per-bank config capture on the first beat, config error pulse.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            wbank_q    <= 1'b0;
            wcnt_q     <= '0;
            cfg_err_q  <= 1'b0;
            cfg_mode_q <= 2'b00;
            for (int b = 0; b < 2; b++) begin
                cfg_n_q[b] <= A_WIDTH'(1);
                cfg_s_q[b] <= A_WIDTH'(1);
            end
        end else begin
            cfg_err_q <= wr_fire & first_beat & bad_cfg;
            if (wr_fire) begin
                if (first_beat) begin
                    cfg_n_q[wbank_q]    <= n_clamp;
                    cfg_s_q[wbank_q]    <= bad_cfg ? A_WIDTH'(1) : step;
                    cfg_mode_q[wbank_q] <= mod_int_dint;
                end
                if (wr_last) begin
                    wcnt_q  <= '0;
                    wbank_q <= ~wbank_q;
                end else begin
                    wcnt_q <= wcnt_q + A_WIDTH'(1);
                end
            end
        end
    end

    // Read FSM: permuted readout of the full bank with registered output stage.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            rd_state_q <= RD_IDLE;
            rbank_q    <= 1'b0;
            rcnt_q     <= '0;
            raddr_q    <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_data_q   <= '0;
        end else begin
            if (rd_issue) begin
                m_data_q  <= mem_q[{rbank_q, raddr_q}];
                m_last_q  <= rd_last;
                m_valid_q <= 1'b1;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end
            case (rd_state_q)
                RD_IDLE: begin
                    rcnt_q  <= '0;
                    raddr_q <= '0;
                    if (full_q[rbank_q]) begin
                        rd_state_q <= RD_RUN;
                    end
                end
                RD_RUN: begin
                    if (rd_issue) begin
                        if (rd_last) begin
                            rcnt_q     <= '0;
                            raddr_q    <= '0;
                            rbank_q    <= ~rbank_q;
                            rd_state_q <= full_q[~rbank_q] ? RD_RUN : RD_IDLE;
                        end else begin
                            rcnt_q  <= rcnt_q + A_WIDTH'(1);
                            raddr_q <= raddr_d;
                        end
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

`ifdef TXI_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    assign frame_cnt = frame_cnt_q;

    // Completed-frame counter, wraps at 16 bits.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            frame_cnt_q <= '0;
        end else if (m_valid_q & m_ready & m_last_q) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end
`endif

endmodule
